// File: rtl/bram_lsu.sv
// Load/store initiator for a 1 KB big-endian byte-lane BRAM (512 x {h,l} bytes).
// Optional MISALIGN_SPLIT_EN: misaligned word accesses become two BRAM cycles instead of an error.
module bram_lsu (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic        i_req_word,
    input  logic        i_req_signed,
    input  logic [9:0]  i_req_addr,
    input  logic [15:0] i_req_wdata,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [15:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic        o_mem_en,
    output logic        o_mem_we_h,
    output logic        o_mem_we_l,
    output logic [8:0]  o_mem_addr,
    output logic [7:0]  o_mem_din_h,
    output logic [7:0]  o_mem_din_l,
    input  logic [7:0]  i_mem_dout_h,
    input  logic [7:0]  i_mem_dout_l
);
    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned WADDR_W = 9;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_P0   = 3'd1;
    localparam logic [2:0] ST_W0   = 3'd2;
`ifdef MISALIGN_SPLIT_EN
    localparam logic [2:0] ST_P1   = 3'd3;
    localparam logic [2:0] ST_W1   = 3'd4;
`endif
    localparam logic [2:0] ST_RSP  = 3'd5;

    logic [2:0]        state;
    logic [2:0]        next_state;
    logic              q_we;
    logic              q_word;
    logic              q_signed;
    logic [ADDR_W-1:0] q_addr;
    logic [DATA_W-1:0] q_wdata;
    logic [DATA_W-1:0] rdata_q;
    logic [BYTE_W-1:0] rd_byte;

`ifdef MISALIGN_SPLIT_EN
    logic split;
    assign split     = q_word & q_addr[0];
    assign o_rsp_err = 1'b0;
`else
    logic req_misalign;
    logic err_q;
    assign req_misalign = i_req_word & i_req_addr[0];
    assign o_rsp_err    = err_q;
`endif

    assign o_req_ready = (state == ST_IDLE) & ~i_rst;
    assign o_rsp_valid = (state == ST_RSP);
    assign o_rsp_rdata = rdata_q;
    assign rd_byte     = q_addr[0] ? i_mem_dout_l : i_mem_dout_h;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (i_req_valid) begin
                    next_state = ST_P0;
`ifndef MISALIGN_SPLIT_EN
                    if (req_misalign) next_state = ST_RSP;
`endif
                end
            end
            ST_P0: begin
                next_state = q_we ? ST_RSP : ST_W0;
`ifdef MISALIGN_SPLIT_EN
                if (q_we && split) next_state = ST_P1;
`endif
            end
            ST_W0: begin
                next_state = ST_RSP;
`ifdef MISALIGN_SPLIT_EN
                if (split) next_state = ST_P1;
`endif
            end
`ifdef MISALIGN_SPLIT_EN
            ST_P1:   next_state = q_we ? ST_RSP : ST_W1;
            ST_W1:   next_state = ST_RSP;
`endif
            ST_RSP:  if (i_rsp_ready) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // BRAM port: active only in the probe states, decoded from the latched request
    always_comb begin
        o_mem_en    = 1'b0;
        o_mem_we_h  = 1'b0;
        o_mem_we_l  = 1'b0;
        o_mem_addr  = '0;
        o_mem_din_h = '0;
        o_mem_din_l = '0;
        case (state)
            ST_P0: begin
                o_mem_en    = 1'b1;
                o_mem_we_h  = q_we & ~q_addr[0];
                o_mem_we_l  = q_we & (q_word | q_addr[0]);
                o_mem_addr  = q_addr[ADDR_W-1:1];
                o_mem_din_h = q_word ? q_wdata[15:8] : q_wdata[7:0];
                o_mem_din_l = (q_word & q_addr[0]) ? q_wdata[15:8] : q_wdata[7:0];
            end
`ifdef MISALIGN_SPLIT_EN
            ST_P1: begin
                o_mem_en    = 1'b1;
                o_mem_we_h  = q_we;
                o_mem_addr  = WADDR_W'(q_addr[ADDR_W-1:1] + 9'd1);
                o_mem_din_h = q_wdata[7:0];
            end
`endif
            default: ;
        endcase
    end

    // Request latch and response capture
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            q_we     <= 1'b0;
            q_word   <= 1'b0;
            q_signed <= 1'b0;
            q_addr   <= '0;
            q_wdata  <= '0;
            rdata_q  <= '0;
`ifndef MISALIGN_SPLIT_EN
            err_q    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        q_we     <= i_req_we;
                        q_word   <= i_req_word;
                        q_signed <= i_req_signed;
                        q_addr   <= i_req_addr;
                        q_wdata  <= i_req_wdata;
                        rdata_q  <= '0;
`ifndef MISALIGN_SPLIT_EN
                        err_q    <= req_misalign;
`endif
                    end
                end
                ST_W0: begin
                    if (q_word) begin
`ifdef MISALIGN_SPLIT_EN
                        if (q_addr[0]) rdata_q[15:8] <= i_mem_dout_l;
                        else
`endif
                        rdata_q <= {i_mem_dout_h, i_mem_dout_l};
                    end else begin
                        rdata_q <= {{BYTE_W{q_signed & rd_byte[7]}}, rd_byte};
                    end
                end
`ifdef MISALIGN_SPLIT_EN
                ST_W1: rdata_q[7:0] <= i_mem_dout_h;
`endif
                ST_RSP: begin
                    if (i_rsp_ready) begin
                        rdata_q <= '0;
`ifndef MISALIGN_SPLIT_EN
                        err_q   <= 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/bram_lsu.md
BRAM_LSU -- requirements
Module: bram_lsu

Interface
REQ-001 Block SHALL be the initiator for the 1 KB byte-lane BRAM port. It SHALL have one clock, i_clk. Reset i_rst SHALL be asynchronous and active-high. The block has no parameters.
REQ-002 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-003 i_rst  in  1  asynchronous active-high reset.
REQ-004 i_req_valid  in  1  request present.
REQ-005 o_req_ready  out  1  block can accept a request.
REQ-006 i_req_we  in  1  1 = write, 0 = read.
REQ-007 i_req_word  in  1  1 = 16-bit access, 0 = byte access.
REQ-008 i_req_signed  in  1  byte read: 1 = sign-extend, 0 = zero-extend.
REQ-009 i_req_addr  in  10  byte address.
REQ-010 i_req_wdata  in  16  write data; byte writes use [7:0].
REQ-011 o_rsp_valid  out  1  response present.
REQ-012 i_rsp_ready  in  1  consumer takes the response.
REQ-013 o_rsp_rdata  out  16  read data; 0 for writes.
REQ-014 o_rsp_err  out  1  access rejected.
REQ-015 o_mem_en, o_mem_we_h, o_mem_we_l  out  1 each  BRAM enable and lane write enables.
REQ-016 o_mem_addr  out  9  BRAM word address (byte address [9:1]).
REQ-017 o_mem_din_h, o_mem_din_l  out  8 each  BRAM write lanes.
REQ-018 i_mem_dout_h, i_mem_dout_l  in  8 each  BRAM read lanes; valid one cycle after the enabled read cycle.

Function
REQ-019 Lane mapping SHALL be big-endian. An even byte address SHALL map to the h lane and an odd byte address to the l lane. A word's wdata[15:8] SHALL be stored at addr and wdata[7:0] at addr+1.
REQ-020 FSM states SHALL be IDLE, P0, W0, P1, W1 and RSP. o_req_ready SHALL be 1 only in IDLE.
REQ-021 When i_req_valid is high in IDLE, the block SHALL latch all request fields, set the next state to P0, and make no BRAM access in the accept cycle.
REQ-022 In P0 and P1 the block SHALL assert o_mem_en and drive o_mem_addr, lane enables and din from the latched request. In all other states o_mem_en, o_mem_we_h and o_mem_we_l SHALL be 0.
REQ-023 Aligned word access (addr[0]=0) SHALL make a single BRAM cycle in P0 with both lanes.
REQ-024 Byte access SHALL make a single BRAM cycle in P0 with only the lane selected by addr[0].
REQ-025 Read transitions: P0 -> W0. In W0, capture the lanes, then go to RSP, or to P1 when a split is needed. P1 -> W1 -> RSP.
REQ-026 Write transitions: P0 -> RSP, or P0 -> P1 -> RSP when split. Writes SHALL never enter W0 or W1.
REQ-027 Byte read result: the selected lane goes to rdata[7:0], and rdata[15:8] is 8 copies of bit 7 if i_req_signed is 1, else 0. Word read: rdata = {byte@addr, byte@addr+1}.
REQ-028 In RSP, o_rsp_valid SHALL be 1 and o_rsp_rdata and o_rsp_err SHALL be held stable until i_rsp_ready is 1. The state SHALL then move to IDLE, and no new request is accepted in that same cycle.
REQ-029 Latency from the accept edge to o_rsp_valid: aligned or byte read = 3 cycles; aligned or byte write = 2; split read = 5; split write = 3.
REQ-030 Only the BRAM outputs captured in W0/W1 SHALL be used; i_mem_dout in any other cycle SHALL be ignored.

Reset
REQ-031 Asserting i_rst at any time, including mid-access, SHALL immediately force IDLE. All o_mem_* outputs SHALL be 0, o_rsp_valid and o_rsp_err 0, and o_rsp_rdata 0x0000.
REQ-032 Any in-flight split access cut by reset SHALL abandon its remaining BRAM cycle. A half-written word is permitted.
REQ-033 o_req_ready SHALL be 1 in the first cycle after i_rst deasserts.

Configuration
REQ-034 Macro MISALIGN_SPLIT_EN defined:
  - A word access with addr[0]=1 SHALL be split into two BRAM cycles.
  - P0 uses word addr[9:1] with the l lane only; P1 uses word addr[9:1]+1 (mod 512, so 0x3FF wraps to word 0) with the h lane only.
  - o_rsp_err SHALL be constant 0.
REQ-035 Macro MISALIGN_SPLIT_EN undefined:
  - A misaligned word access SHALL make no BRAM cycle. The FSM goes IDLE -> RSP with o_rsp_err=1 and rdata 0x0000, so o_rsp_valid rises 1 cycle after accept.
  - States P1 and W1 SHALL be absent.

Verification
REQ-036 Word write 0xA55A at addr 0x010, then word read at 0x010 -> rdata 0xA55A, err 0, read rsp_valid 3 cycles after accept.
REQ-037 Byte write 0x7F at 0x011, then byte read at 0x010 with signed=1 -> 0xFFA5; byte read at 0x011 with signed=0 -> 0x007F; byte write asserts only o_mem_we_l.
REQ-038 Word write 0x1234 at 0x3FF with the macro defined -> byte 0x3FF=0x12 and byte 0x000=0x34; word read at 0x3FF -> 0x1234 at 5 cycles. With the macro undefined -> err=1, rdata 0x0000, no o_mem_en pulse.
REQ-039 Hold i_rsp_ready=0 for 4 cycles in RSP -> o_rsp_valid and o_rsp_rdata stay stable, o_req_ready=0, no BRAM activity.
REQ-040 Assert i_rst during P1 of a split write -> all outputs 0 in the same cycle, no P1 BRAM write occurs, and o_req_ready=1 after release.
